// File: rtl/dot_pkg.sv
// rtl/dot_pkg.sv - shared constants and result entry type for the dot-product accumulator
// Purpose: default accumulator width, saturation bounds at that width and the
//          default result FIFO entry {data, ovf}.
// Ports:   none (package).
package dot_pkg;

   localparam int DEF_ACC_W = 32;

   localparam logic signed [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
   localparam logic signed [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

   typedef struct packed {
      logic signed [DEF_ACC_W-1:0] data;
      logic                        ovf;
   } dot_res_t;

endpackage

// File: rtl/dot_res_fifo.sv
// rtl/dot_res_fifo.sv - synchronous result FIFO with occupancy count
// Purpose: holds finished dot-product results until downstream takes them.
// Ports:   i_clk/i_rst_n   clock, async active-low reset
//          i_push/i_data   write an entry (caller guarantees space or a same-edge pop)
//          i_pop           remove the head (caller gates with o_valid)
//          o_valid/o_data  head entry present / head entry
//          o_count         number of stored entries
module dot_res_fifo
   import dot_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = dot_res_t
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  T                           i_data,
   input  logic                       i_pop,
   output logic                       o_valid,
   output T                           o_data,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   T              r_mem [DEPTH];
   logic [PW-1:0] r_rd;
   logic [PW-1:0] r_wr;
   logic [CW-1:0] r_count;

   // Pointer wrap that also works for non power-of-two depths.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (i_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= ptr_inc(r_wr);
         end
         if (i_pop) begin
            r_rd <= ptr_inc(r_rd);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_valid = (r_count != '0);
   assign o_data  = r_mem[r_rd];
   assign o_count = r_count;

endmodule

// File: rtl/dot_accum_s.sv
// rtl/dot_accum_s.sv - saturating signed dot-product accumulator behind the adder tree
// Purpose: aligns beat tags with the adder-tree output, accumulates tree sums
//          with saturation, queues final results and issues upstream credit.
// Ports:   i_clk/i_rst_n              clock, async active-low reset
//          i_in_valid/i_in_last       upstream beat offer and end-of-vector tag
//          o_in_ready                 upstream credit (from state only)
//          i_tree_sum                 signed adder-tree output
//          o_out_valid/i_out_ready    result handshake
//          o_out_data/o_out_ovf       result value and saturation flag
module dot_accum_s
   import dot_pkg::*;
#(
   parameter int IN_W      = 16,
   parameter int ACC_W     = DEF_ACC_W,
   parameter int TREE_LAT  = 8,
   parameter int OUT_DEPTH = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_in_valid,
   input  logic                    i_in_last,
   output logic                    o_in_ready,
   input  logic signed [IN_W-1:0]  i_tree_sum,
   output logic                    o_out_valid,
   input  logic                    i_out_ready,
   output logic signed [ACC_W-1:0] o_out_data,
   output logic                    o_out_ovf
);

   localparam int CW = $clog2(OUT_DEPTH + 1);
   localparam logic signed [ACC_W-1:0] L_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] L_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef struct packed {
      logic signed [ACC_W-1:0] data;
      logic                    ovf;
   } res_t;

   logic [TREE_LAT-1:0]     r_tag_v;
   logic [TREE_LAT-1:0]     r_tag_last;
   logic                    r_first;
   logic signed [ACC_W-1:0] r_acc;
   logic                    r_ovf_acc;

   logic                    w_accept;
   logic                    w_tag_v;
   logic                    w_tag_last;
   logic signed [ACC_W-1:0] w_base;
   logic signed [ACC_W:0]   w_sum_wide;
   logic                    w_ovf_now;
   logic signed [ACC_W-1:0] w_sum;
   logic                    w_ovf;
   logic                    w_push;
   logic                    w_pop;
   logic [CW-1:0]           w_count;
   res_t                    w_push_entry;
   res_t                    w_head;
   int                      w_pending;

   assign w_accept   = i_in_valid & o_in_ready;
   assign w_tag_v    = r_tag_v[TREE_LAT-1];
   assign w_tag_last = r_tag_last[TREE_LAT-1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tag_v    <= '0;
         r_tag_last <= '0;
      end else begin
         for (int i = TREE_LAT - 1; i > 0; i--) begin
            r_tag_v[i]    <= r_tag_v[i-1];
            r_tag_last[i] <= r_tag_last[i-1];
         end
         r_tag_v[0]    <= w_accept;
         r_tag_last[0] <= i_in_last;
      end
   end

   // One extra bit of headroom: overflow shows up as the top two bits differing.
   assign w_base     = r_first ? '0 : r_acc;
   assign w_sum_wide = {w_base[ACC_W-1], w_base}
                     + {{(ACC_W + 1 - IN_W){i_tree_sum[IN_W-1]}}, i_tree_sum};
   assign w_ovf_now  = w_sum_wide[ACC_W] ^ w_sum_wide[ACC_W-1];
   assign w_sum      = !w_ovf_now        ? w_sum_wide[ACC_W-1:0] :
                       w_sum_wide[ACC_W] ? L_MIN : L_MAX;
   // The sticky flag only carries over within a vector.
   assign w_ovf      = w_ovf_now | (~r_first & r_ovf_acc);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_first   <= 1'b1;
         r_acc     <= '0;
         r_ovf_acc <= 1'b0;
      end else if (w_tag_v) begin
         if (w_tag_last) begin
            r_first <= 1'b1;
         end else begin
            r_first   <= 1'b0;
            r_acc     <= w_sum;
            r_ovf_acc <= w_ovf;
         end
      end
   end

   assign w_push       = w_tag_v & w_tag_last;
   assign w_pop        = o_out_valid & i_out_ready;
   assign w_push_entry = '{data: w_sum, ovf: w_ovf};

   // Every last beat still in the tree has a FIFO slot reserved for it, so a
   // push can never land on a full FIFO regardless of downstream stalls.
   always_comb begin
      w_pending = int'(w_count);
      for (int i = 0; i < TREE_LAT; i++) begin
         w_pending = w_pending + int'(r_tag_v[i] & r_tag_last[i]);
      end
   end

   assign o_in_ready = (w_pending < OUT_DEPTH);

   dot_res_fifo #(
      .DEPTH (OUT_DEPTH),
      .T     (res_t)
   ) u_res_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_data  (w_push_entry),
      .i_pop   (w_pop),
      .o_valid (o_out_valid),
      .o_data  (w_head),
      .o_count (w_count)
   );

   assign o_out_data = w_head.data;
   assign o_out_ovf  = w_head.ovf;

endmodule

// File: tb/tb_dot_accum_s.sv
// tb/tb_dot_accum_s.sv - directed self-checking bench for dot_accum_s
module tb_dot_accum_s;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_last = 1'b0;
   logic               out_ready = 1'b0;
   logic signed [15:0] din = '0;
   logic signed [15:0] t0 = '0, t1 = '0, t2 = '0;
   logic               in_ready;
   logic               out_valid;
   logic               out_ovf;
   logic [19:0]        out_data;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int acc_cyc = 0;

   typedef struct {
      logic [19:0] data;
      logic        ovf;
      int          cyc;
   } res_t;
   res_t q[$];

   dot_accum_s #(
      .IN_W(16), .ACC_W(20), .TREE_LAT(3), .OUT_DEPTH(2)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_in_valid  (in_valid),
      .i_in_last   (in_last),
      .o_in_ready  (in_ready),
      .i_tree_sum  (t2),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_data  (out_data),
      .o_out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   // Model adder tree: three register stages, never reset.
   always @(posedge clk) begin
      t0  <= din;
      t1  <= t0;
      t2  <= t1;
      cyc <= cyc + 1;
   end

   // Record every result consumed at the coming edge, tagged with the cycle it was visible in.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) q.push_back('{out_data, out_ovf, cyc});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      din      = '0;
   endtask

   task automatic beat(input int v, input bit last);
      bit rdy;
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_last  = last;
      din      = 16'(v);
      do begin
         rdy = in_ready;
         tick();
         n++;
      end while (!rdy && n < 100);
      n_cmp++;
      if (!rdy) begin
         n_bad++;
         $display("FAIL beat_accept: value %0d not accepted after %0d cycles", v, n);
      end
      acc_cyc = cyc;
   endtask

   task automatic wait_q(input int n);
      int k;
      k = 0;
      while (q.size() < n && k < 100) begin
         tick();
         k++;
      end
   endtask

   function automatic res_t get();
      if (q.size() > 0) return q.pop_front();
      return '{20'h0, 1'b0, -1};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      tick(); tick();
      rst_n = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 20'h0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      n_cmp++; if (out_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf); end
      tick();
   endtask

   task automatic test_basic();
      res_t r;
      int   k;
      out_ready = 1'b1;
      q.delete();
      beat(100, 0);
      beat(-30, 0);
      beat(7, 1);
      k = acc_cyc;
      idle();
      wait_q(1);
      r = get();
      n_cmp++; if (r.data !== 20'd77) begin n_bad++; $display("FAIL basic_data: got %0d want 77", $signed(r.data)); end
      n_cmp++; if (r.ovf !== 1'b0) begin n_bad++; $display("FAIL basic_ovf: got %b want 0", r.ovf); end
      n_cmp++; if (r.cyc !== k + 3) begin n_bad++; $display("FAIL basic_latency: valid in cycle %0d want %0d", r.cyc, k + 3); end
   endtask

   task automatic test_sign();
      res_t r;
      q.delete();
      beat(-32768, 1);
      idle();
      wait_q(1);
      r = get();
      n_cmp++; if (r.data !== 20'hF8000) begin n_bad++; $display("FAIL sign_data: got %h want f8000", r.data); end
      n_cmp++; if (r.ovf !== 1'b0) begin n_bad++; $display("FAIL sign_ovf: got %b want 0", r.ovf); end
      beat(5, 1);
      idle();
      wait_q(1);
      r = get();
      n_cmp++; if (r.data !== 20'd5) begin n_bad++; $display("FAIL restart_data: got %0d want 5", $signed(r.data)); end
      n_cmp++; if (r.ovf !== 1'b0) begin n_bad++; $display("FAIL restart_ovf: got %b want 0", r.ovf); end
   endtask

   task automatic test_saturation();
      res_t r;
      q.delete();
      for (int i = 0; i < 39; i++) beat(32767, 0);
      beat(32767, 1);
      idle();
      wait_q(1);
      r = get();
      n_cmp++; if (r.data !== 20'h7FFFF) begin n_bad++; $display("FAIL sat_data: got %h want 7ffff", r.data); end
      n_cmp++; if (r.ovf !== 1'b1) begin n_bad++; $display("FAIL sat_ovf: got %b want 1", r.ovf); end
      beat(1, 1);
      idle();
      wait_q(1);
      r = get();
      n_cmp++; if (r.data !== 20'd1) begin n_bad++; $display("FAIL post_sat_data: got %0d want 1", $signed(r.data)); end
      n_cmp++; if (r.ovf !== 1'b0) begin n_bad++; $display("FAIL post_sat_ovf: got %b want 0", r.ovf); end
   endtask

   task automatic test_backpressure();
      res_t r;
      out_ready = 1'b0;
      q.delete();
      beat(1, 1);
      beat(2, 1);
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_drop: got %b want 0", in_ready); end
      din = 16'sd3;
      repeat (6) tick();
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_hold: got %b want 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_data !== 20'd1) begin n_bad++; $display("FAIL bp_head: got %0d want 1", $signed(out_data)); end
      out_ready = 1'b1;
      beat(3, 1);
      idle();
      wait_q(3);
      for (int i = 0; i < 3; i++) begin
         r = get();
         n_cmp++; if (r.data !== 20'(i + 1)) begin n_bad++; $display("FAIL bp_order: result %0d got %0d want %0d", i, $signed(r.data), i + 1); end
      end
      repeat (10) tick();
      n_cmp++; if (q.size() !== 0) begin n_bad++; $display("FAIL bp_extra: got %0d extra results want 0", q.size()); end
   endtask

   task automatic test_back_to_back();
      res_t r;
      int   a [6];
      int   rc [6];
      out_ready = 1'b1;
      q.delete();
      beat(10, 1); a[0] = acc_cyc;
      beat(11, 1); a[1] = acc_cyc;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_drop: got %b want 0", in_ready); end
      for (int i = 2; i < 6; i++) begin
         beat(10 + i, 1);
         a[i] = acc_cyc;
      end
      idle();
      wait_q(6);
      for (int i = 0; i < 6; i++) begin
         r = get();
         rc[i] = r.cyc;
         n_cmp++; if (r.data !== 20'(10 + i)) begin n_bad++; $display("FAIL b2b_data: result %0d got %0d want %0d", i, $signed(r.data), 10 + i); end
      end
      n_cmp++; if (a[1] !== a[0] + 1) begin n_bad++; $display("FAIL b2b_accept1: edge %0d want %0d", a[1], a[0] + 1); end
      n_cmp++; if (a[2] !== a[1] + 4) begin n_bad++; $display("FAIL b2b_accept2: edge %0d want %0d", a[2], a[1] + 4); end
      n_cmp++; if (a[3] !== a[2] + 1) begin n_bad++; $display("FAIL b2b_accept3: edge %0d want %0d", a[3], a[2] + 1); end
      n_cmp++; if (rc[0] !== a[0] + 3) begin n_bad++; $display("FAIL b2b_lat: cycle %0d want %0d", rc[0], a[0] + 3); end
      n_cmp++; if (rc[1] !== rc[0] + 1) begin n_bad++; $display("FAIL b2b_rate: cycle %0d want %0d", rc[1], rc[0] + 1); end
   endtask

   task automatic test_reset_mid();
      res_t r;
      out_ready = 1'b1;
      q.delete();
      beat(50, 0);
      beat(60, 0);
      idle();
      #2 rst_n = 1'b0;
      tick(); tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
      rst_n = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_data !== 20'h0) begin n_bad++; $display("FAIL rst_mid_data: got %h want 0", out_data); end
      repeat (6) tick();
      n_cmp++; if (q.size() !== 0) begin n_bad++; $display("FAIL rst_mid_residue: got %0d results want 0", q.size()); end
      beat(9, 1);
      idle();
      wait_q(1);
      r = get();
      n_cmp++; if (r.data !== 20'd9) begin n_bad++; $display("FAIL rst_mid_new: got %0d want 9", $signed(r.data)); end
      n_cmp++; if (r.ovf !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ovf: got %b want 0", r.ovf); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sign();
      test_saturation();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
